// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES sizes, scheduler state type and GF(2^8) S-box helpers
// Contents: AES_WORD_SIZE, AES_WORDS_PER_BLOCK, aes_state_e,
//           sbox_fwd / sbox_inv byte functions used by the S-box modules.
package aes_pkg;

   localparam int AES_WORD_SIZE       = 32;
   localparam int AES_WORDS_PER_BLOCK = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DATA_BUSY = 2'd1,
      ST_DATA_DONE = 2'd2,
      ST_KEY_DONE  = 2'd3
   } aes_state_e;

   // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = gf_xtime(aa);
      end
      return p;
   endfunction

   // Inverse as x^254 = product of x^(2^i) for i = 1..7; zero maps to zero
   // which is exactly the S-box convention.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
             {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      logic [7:0] v;
      v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(v);
   endfunction

endpackage

// File: rtl/aes_defines.svh
// rtl/aes_defines.svh - AES width macros shared by the sub-bytes datapath
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES_BLOCK_SIZE 128

`endif

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - inverse AES S-box, one byte, combinational
// Ports: in_byte (8) in, out_byte (8) out.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_inv(in_byte);

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box, one byte, combinational
// Ports: in_byte (8) in, out_byte (8) out.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_fwd(in_byte);

endmodule

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - 32-bit sub-word unit, forward or inverse S-box per byte
// Ports: encrypt in (1 = forward, 0 = inverse), word_in (32) in, word_out (32) out.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic                     encrypt,
   input  logic [AES_WORD_SIZE-1:0] word_in,
   output logic [AES_WORD_SIZE-1:0] word_out
);

   logic [AES_WORD_SIZE-1:0] fwd_word;
   logic [AES_WORD_SIZE-1:0] inv_word;

   for (genvar i = 0; i < AES_WORD_SIZE / 8; i++) begin : g_byte
      aes_sbox u_sbox (
         .in_byte  (word_in[8*i +: 8]),
         .out_byte (fwd_word[8*i +: 8])
      );
      aes_inv_sbox u_inv_sbox (
         .in_byte  (word_in[8*i +: 8]),
         .out_byte (inv_word[8*i +: 8])
      );
   end

   assign word_out = encrypt ? fwd_word : inv_word;

endmodule

// File: rtl/aes_sub_bytes_scheduler.sv
// rtl/aes_sub_bytes_scheduler.sv - shares one sub-word unit between data and key requesters
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   data_valid/data_ready           block request handshake, data_encrypt, data_in (128)
//   data_out_valid/data_out_ready   substituted block handshake, data_out (128)
//   key_valid/key_ready             key word request handshake, key_in (32)
//   key_out_valid/key_out_ready     substituted key word handshake, key_out (32)
// KEY_PRIORITY: 1 = key requester wins a simultaneous request, 0 = data wins.
`include "aes_defines.svh"
module aes_sub_bytes_scheduler
   import aes_pkg::*;
#(
   parameter int KEY_PRIORITY = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       data_valid,
   output logic                       data_ready,
   input  logic                       data_encrypt,
   input  logic [`AES_BLOCK_SIZE-1:0] data_in,
   output logic                       data_out_valid,
   input  logic                       data_out_ready,
   output logic [`AES_BLOCK_SIZE-1:0] data_out,
   input  logic                       key_valid,
   output logic                       key_ready,
   input  logic [AES_WORD_SIZE-1:0]   key_in,
   output logic                       key_out_valid,
   input  logic                       key_out_ready,
   output logic [AES_WORD_SIZE-1:0]   key_out
);

   localparam logic KEY_WINS = (KEY_PRIORITY != 0);

   aes_state_e state;
   logic [1:0] beat;
   logic       enc_q;
   logic [AES_WORDS_PER_BLOCK-1:0][AES_WORD_SIZE-1:0] blk_q;
   logic [AES_WORDS_PER_BLOCK-1:0][AES_WORD_SIZE-1:0] data_out_q;
   logic [AES_WORD_SIZE-1:0] key_out_q;
   logic [AES_WORD_SIZE-1:0] sub_in;
   logic [AES_WORD_SIZE-1:0] sub_out;
   logic sub_enc;
   logic idle;
   logic data_acc;
   logic key_acc;

   assign idle       = (state == ST_IDLE);
   assign data_ready = idle & ~(key_valid & KEY_WINS);
   assign key_ready  = idle & ~(data_valid & ~KEY_WINS);
   assign data_acc   = data_valid & data_ready;
   assign key_acc    = key_valid & key_ready;

   // Outside DATA_BUSY the unit always looks at key_in in forward mode, so a
   // key result is ready to register on the very edge that accepts it.
   assign sub_in  = (state == ST_DATA_BUSY) ? blk_q[beat] : key_in;
   assign sub_enc = (state == ST_DATA_BUSY) ? enc_q : 1'b1;

   aes_sub_word u_sub_word (
      .encrypt  (sub_enc),
      .word_in  (sub_in),
      .word_out (sub_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         beat       <= 2'd0;
         enc_q      <= 1'b0;
         blk_q      <= '0;
         data_out_q <= '0;
         key_out_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (data_acc) begin
                  blk_q <= data_in;
                  enc_q <= data_encrypt;
                  beat  <= 2'd0;
                  state <= ST_DATA_BUSY;
               end else if (key_acc) begin
                  key_out_q <= sub_out;
                  state     <= ST_KEY_DONE;
               end
            end
            ST_DATA_BUSY: begin
               data_out_q[beat] <= sub_out;
               beat             <= beat + 2'd1;
               // Leaving on the last word keeps the counter wrap harmless.
               if (beat == 2'd3) state <= ST_DATA_DONE;
            end
            ST_DATA_DONE: begin
               if (data_out_ready) state <= ST_IDLE;
            end
            ST_KEY_DONE: begin
               if (key_out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign data_out_valid = (state == ST_DATA_DONE);
   assign key_out_valid  = (state == ST_KEY_DONE);
   assign data_out       = data_out_q;
   assign key_out        = key_out_q;

endmodule

// File: tb/tb_aes_sub_bytes_scheduler.sv
// tb/tb_aes_sub_bytes_scheduler.sv - scoreboard bench for aes_sub_bytes_scheduler
module tb_aes_sub_bytes_scheduler;

   typedef struct {
      bit           is_key;
      logic [127:0] val;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut_a: KEY_PRIORITY = 1, dut_b: KEY_PRIORITY = 0
   logic         a_dv = 1'b0, a_enc = 1'b0, a_dor = 1'b1, a_kv = 1'b0, a_kor = 1'b1;
   logic         a_dr, a_dov, a_kr, a_kov;
   logic [127:0] a_din = '0;
   logic [127:0] a_dout;
   logic [31:0]  a_kin = '0;
   logic [31:0]  a_kout;

   logic         b_dv = 1'b0, b_enc = 1'b0, b_dor = 1'b1, b_kv = 1'b0, b_kor = 1'b1;
   logic         b_dr, b_dov, b_kr, b_kov;
   logic [127:0] b_din = '0;
   logic [127:0] b_dout;
   logic [31:0]  b_kin = '0;
   logic [31:0]  b_kout;

   aes_sub_bytes_scheduler #(.KEY_PRIORITY(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .data_valid(a_dv), .data_ready(a_dr), .data_encrypt(a_enc), .data_in(a_din),
      .data_out_valid(a_dov), .data_out_ready(a_dor), .data_out(a_dout),
      .key_valid(a_kv), .key_ready(a_kr), .key_in(a_kin),
      .key_out_valid(a_kov), .key_out_ready(a_kor), .key_out(a_kout)
   );

   aes_sub_bytes_scheduler #(.KEY_PRIORITY(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .data_valid(b_dv), .data_ready(b_dr), .data_encrypt(b_enc), .data_in(b_din),
      .data_out_valid(b_dov), .data_out_ready(b_dor), .data_out(b_dout),
      .key_valid(b_kv), .key_ready(b_kr), .key_in(b_kin),
      .key_out_valid(b_kov), .key_out_ready(b_kor), .key_out(b_kout)
   );

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // Monitors: pop and compare on every output handshake seen at negedge.
   always @(negedge clk) begin
      exp_t e;
      if (a_dov | a_kov) check("a_valid_exclusive", {127'd0, a_dov & a_kov}, 128'd0);
      if (a_dov & a_dor) begin
         if (exp_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_unexpected_data: got 0x%0h, expected no output", a_dout);
         end else begin
            e = exp_a.pop_front();
            check("a_data_order", {127'd0, e.is_key}, 128'd0);
            check("a_data_value", a_dout, e.val);
         end
      end
      if (a_kov & a_kor) begin
         if (exp_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_unexpected_key: got 0x%0h, expected no output", a_kout);
         end else begin
            e = exp_a.pop_front();
            check("a_key_order", {127'd0, e.is_key}, 128'd1);
            check("a_key_value", {96'd0, a_kout}, e.val);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_dov | b_kov) check("b_valid_exclusive", {127'd0, b_dov & b_kov}, 128'd0);
      if (b_dov & b_dor) begin
         if (exp_b.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL b_unexpected_data: got 0x%0h, expected no output", b_dout);
         end else begin
            e = exp_b.pop_front();
            check("b_data_order", {127'd0, e.is_key}, 128'd0);
            check("b_data_value", b_dout, e.val);
         end
      end
      if (b_kov & b_kor) begin
         if (exp_b.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL b_unexpected_key: got 0x%0h, expected no output", b_kout);
         end else begin
            e = exp_b.pop_front();
            check("b_key_order", {127'd0, e.is_key}, 128'd1);
            check("b_key_value", {96'd0, b_kout}, e.val);
         end
      end
   end

   // Edges after the acceptance edge until valid is seen: data 4, key 0.
   task automatic send_data_a(input logic [127:0] blk, input logic enc,
                              input logic [127:0] expv, input int hold);
      bit ok;
      int lat;
      @(posedge clk); #1;
      a_din = blk; a_enc = enc; a_dv = 1'b1; a_dor = (hold == 0);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = a_dr; end
      if (!ok) begin fail_now("a_data_accept"); a_dv = 1'b0; return; end
      exp_a.push_back('{1'b0, expv});
      @(posedge clk); #1;
      a_dv = 1'b0; a_din = ~blk; a_enc = ~enc;
      lat = 0; ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk); ok = a_dov;
         if (!ok) lat++;
      end
      check("a_data_latency", 128'(lat), 128'd4);
      for (int h = 0; h < hold; h++) begin
         check("a_data_hold_valid", {127'd0, a_dov}, 128'd1);
         check("a_data_hold_value", a_dout, expv);
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_dor = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = !a_dov; end
      if (!ok) fail_now("a_data_drain");
   endtask

   task automatic send_key_a(input logic [31:0] kin, input logic [31:0] expv, input int hold);
      bit ok;
      int lat;
      @(posedge clk); #1;
      a_kin = kin; a_kv = 1'b1; a_kor = (hold == 0);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = a_kr; end
      if (!ok) begin fail_now("a_key_accept"); a_kv = 1'b0; return; end
      exp_a.push_back('{1'b1, {96'd0, expv}});
      @(posedge clk); #1;
      a_kv = 1'b0; a_kin = ~kin;
      lat = 0; ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk); ok = a_kov;
         if (!ok) lat++;
      end
      check("a_key_latency", 128'(lat), 128'd0);
      for (int h = 0; h < hold; h++) begin
         check("a_key_hold_valid", {127'd0, a_kov}, 128'd1);
         check("a_key_hold_value", {96'd0, a_kout}, {96'd0, expv});
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_kor = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = !a_kov; end
      if (!ok) fail_now("a_key_drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit seen;
      int n;

      repeat (2) @(negedge clk);
      check("rst_a_data_out_valid", {127'd0, a_dov}, 128'd0);
      check("rst_a_key_out_valid", {127'd0, a_kov}, 128'd0);
      check("rst_a_data_out", a_dout, 128'd0);
      check("rst_a_key_out", {96'd0, a_kout}, 128'd0);
      check("rst_b_data_out_valid", {127'd0, b_dov}, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      send_data_a(128'd0, 1'b1, {4{32'h63636363}}, 0);
      send_data_a({4{32'h63636363}}, 1'b0, 128'd0, 0);
      send_data_a({96'd0, 32'h00000053}, 1'b1, {{3{32'h63636363}}, 32'h636363ED}, 0);
      send_data_a({{3{32'h63636363}}, 32'h636363ED}, 1'b0, {96'd0, 32'h00000053}, 3);
      send_key_a(32'h00000001, 32'h6363637C, 5);
      send_key_a(32'h53000000, 32'hED636363, 0);

      // Simultaneous requests, key wins on dut_a.
      @(posedge clk); #1;
      a_din = 128'd0; a_enc = 1'b1; a_kin = 32'h53000000;
      a_dv = 1'b1; a_kv = 1'b1;
      exp_a.push_back('{1'b1, {96'd0, 32'hED636363}});
      exp_a.push_back('{1'b0, {4{32'h63636363}}});
      @(negedge clk);
      check("a_prio_key_ready", {127'd0, a_kr}, 128'd1);
      check("a_prio_data_ready", {127'd0, a_dr}, 128'd0);
      @(posedge clk); #1;
      a_kv = 1'b0; a_kin = 32'hFFFFFFFF;
      @(negedge clk);
      check("a_prio_key_done", {127'd0, a_kov}, 128'd1);
      check("a_prio_data_blocked", {127'd0, a_dr}, 128'd0);
      @(negedge clk);
      check("a_prio_data_next", {127'd0, a_dr}, 128'd1);
      @(posedge clk); #1;
      a_dv = 1'b0; a_din = '1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = a_dov; end
      if (!ok) fail_now("a_prio_data_out");
      repeat (3) @(negedge clk);

      // Simultaneous requests, data wins on dut_b.
      @(posedge clk); #1;
      b_din = {32'h01000000, 96'd0}; b_enc = 1'b1; b_kin = 32'h00000000;
      b_dv = 1'b1; b_kv = 1'b1;
      exp_b.push_back('{1'b0, {32'h7C636363, {3{32'h63636363}}}});
      exp_b.push_back('{1'b1, {96'd0, 32'h63636363}});
      @(negedge clk);
      check("b_prio_data_ready", {127'd0, b_dr}, 128'd1);
      check("b_prio_key_ready", {127'd0, b_kr}, 128'd0);
      @(posedge clk); #1;
      b_dv = 1'b0; b_din = '1; b_enc = 1'b0;
      n = 0; ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); n++; ok = b_kr; end
      check("b_prio_key_wait", 128'(n), 128'd6);
      @(posedge clk); #1;
      b_kv = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during beat 2 of a data job on dut_a.
      @(posedge clk); #1;
      a_din = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00}; a_enc = 1'b1; a_dv = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = a_dr; end
      if (!ok) fail_now("a_reset_job_accept");
      @(posedge clk); #1;
      a_dv = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_data_out", a_dout, 128'd0);
      check("rst_mid_key_out", {96'd0, a_kout}, 128'd0);
      check("rst_mid_data_valid", {127'd0, a_dov}, 128'd0);
      check("rst_mid_key_valid", {127'd0, a_kov}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin @(negedge clk); if (a_dov) seen = 1; end
      check("rst_no_stale_valid", {127'd0, seen}, 128'd0);

      send_data_a({32'h00000001, 32'h00000000, 32'h00000053, 32'h00000000}, 1'b1,
                  {32'h6363637C, 32'h63636363, 32'h636363ED, 32'h63636363}, 0);

      repeat (4) @(negedge clk);
      check("a_queue_drained", 128'(exp_a.size()), 128'd0);
      check("b_queue_drained", 128'(exp_b.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_sub_bytes_scheduler.md
AES_SUB_BYTES_SCHEDULER -- requirements
Module: aes_sub_bytes_scheduler

Interface
REQ-001 Parameter: KEY_PRIORITY, default 1, 1 = key requester wins simultaneous requests, 0 = data requester wins.
REQ-002 Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset.
REQ-004 Data_valid  input  1  data requester presents a 128-bit block.
REQ-005 Data_ready  output  1  block accepted when Data_valid & Data_ready at a rising edge.
REQ-006 Data_encrypt  input  1  1 = forward S-box, 0 = inverse S-box; sampled only at acceptance.
REQ-007 Data_in  input  `AES_BLOCK_SIZE  input block; word k = bits [32k+31:32k].
REQ-008 Data_out_valid  output  1  substituted block available.
REQ-009 Data_out_ready  input  1  consumer takes Data_out.
REQ-010 Data_out  output  `AES_BLOCK_SIZE  substituted block.
REQ-011 Key_valid  input  1  key-expansion requester presents a 32-bit word.
REQ-012 Key_ready  output  1  word accepted when Key_valid & Key_ready at a rising edge.
REQ-013 Key_in  input  32  word to substitute (always forward S-box).
REQ-014 Key_out_valid  output  1  substituted word available.
REQ-015 Key_out_ready  input  1  consumer takes Key_out.
REQ-016 Key_out  output  32  substituted word.

Function
REQ-017 One shared 32-bit sub-word unit (4 forward + 4 inverse S-boxes), time-multiplexed between requesters; exactly one job in flight.
REQ-018 States: IDLE, DATA_BUSY, DATA_DONE, KEY_DONE.
REQ-019 Data_ready = (IDLE) & ~(Key_valid & KEY_PRIORITY); Key_ready = (IDLE) & ~(Data_valid & ~KEY_PRIORITY).
REQ-020 Data acceptance: Data_in and Data_encrypt latched, beat counter cleared to 0, IDLE -> DATA_BUSY.
REQ-021 DATA_BUSY: each cycle the unit substitutes latched word[counter] in the latched mode; result written into Data_out word[counter]; counter increments.
REQ-022 Counter is 2 bits; when counter = 3 the write completes and DATA_BUSY -> DATA_DONE (no wrap into a 5th beat).
REQ-023 Data latency: Data_out_valid rises exactly 4 cycles after the acceptance edge.
REQ-024 Key acceptance: unit input muxed to Key_in in IDLE, forward mode; result registered into Key_out at the acceptance edge; IDLE -> KEY_DONE; Key_out_valid high 1 cycle after acceptance.
REQ-025 DATA_DONE / KEY_DONE: respective output valid held high, output value held stable until its ready is high; handshake edge -> IDLE.
REQ-026 No new acceptance in DATA_BUSY, DATA_DONE or KEY_DONE; both readies low there; earliest next acceptance is the cycle after the output handshake.
REQ-027 Input changes on Data_encrypt/Data_in after acceptance have no effect on the in-flight job.
REQ-028 Data_out_valid and Key_out_valid are never high simultaneously.

Reset
REQ-029 Rst_n low: state = IDLE, counter = 0, Data_out = 0, Key_out = 0, both output valids = 0, latched block/mode = 0, effective immediately (asynchronous).
REQ-030 Reset mid-job discards the in-flight job; no output valid asserted for it after release.
REQ-031 After Rst_n deasserts, first acceptance possible at the first rising edge.

Structure
REQ-032 Shared package aes_pkg holds state enum type, AES_WORD_SIZE = 32, AES_WORDS_PER_BLOCK = 4; block width from `AES_BLOCK_SIZE in aes_defines.svh.
REQ-033 One sub-module aes_sub_word: combinational, Encrypt + 32-bit in/out, built from aes_sbox / aes_inv_sbox instances.

Verification
REQ-034 Data_in = all 0x00, Data_encrypt = 1 -> Data_out = all 0x63, Data_out_valid 4 cycles after acceptance.
REQ-035 Data_in = all 0x63, Data_encrypt = 0 -> Data_out = all 0x00; Data_in word0 = 0x00000053, others 0 -> word0 = 0x636363ED, encrypt mode.
REQ-036 Key_in = 0x00000001 -> Key_out = 0x6363637C one cycle after acceptance; Key_out_ready held low 5 cycles -> value and valid stable.
REQ-037 Data_valid and Key_valid rise same cycle, KEY_PRIORITY = 1 -> key served first, data accepted the cycle after key handshake; repeat with KEY_PRIORITY = 0 -> reversed order.
REQ-038 Rst_n pulsed low during DATA_BUSY beat 2 -> all outputs 0 immediately, no Data_out_valid afterwards, next block processes correctly.
